// File: rtl/rs_multi_cdb_if.sv
// Dispatch, result-broadcast and issue bundle of the reservation station.
// slave = reservation station view, master = dispatch/CDB/ALU environment view.
interface rs_multi_cdb_if #(
    parameter int DEPTH_BIT = 3,
    parameter int ROB_BIT   = 4,
    parameter int TYPE_BIT  = 5,
    parameter int XLEN      = 32,
    parameter int NUM_CDB   = 2
);
    logic                        in_valid;
    logic                        in_ready;
    logic [TYPE_BIT-1:0]         in_type;
    logic [ROB_BIT-1:0]          in_rob_id;
    logic [XLEN-1:0]             in_r1;
    logic [XLEN-1:0]             in_r2;
    logic                        in_has_dep1;
    logic                        in_has_dep2;
    logic [ROB_BIT-1:0]          in_dep1;
    logic [ROB_BIT-1:0]          in_dep2;
    logic [NUM_CDB-1:0]          cdb_valid;
    logic [NUM_CDB*ROB_BIT-1:0]  cdb_rob_id;
    logic [NUM_CDB*XLEN-1:0]     cdb_value;
    logic                        iss_valid;
    logic                        iss_ready;
    logic [TYPE_BIT-1:0]         iss_type;
    logic [ROB_BIT-1:0]          iss_rob_id;
    logic [XLEN-1:0]             iss_r1;
    logic [XLEN-1:0]             iss_r2;
    logic [DEPTH_BIT:0]          count;

    modport slave (
        input  in_valid, in_type, in_rob_id, in_r1, in_r2,
               in_has_dep1, in_has_dep2, in_dep1, in_dep2,
               cdb_valid, cdb_rob_id, cdb_value, iss_ready,
        output in_ready, iss_valid, iss_type, iss_rob_id, iss_r1, iss_r2, count
    );

    modport master (
        output in_valid, in_type, in_rob_id, in_r1, in_r2,
               in_has_dep1, in_has_dep2, in_dep1, in_dep2,
               cdb_valid, cdb_rob_id, cdb_value, iss_ready,
        input  in_ready, iss_valid, iss_type, iss_rob_id, iss_r1, iss_r2, count
    );
endinterface

// File: rtl/rs_multi_cdb.sv
// Reservation station: buffers ops, wakes operands from NUM_CDB broadcasts, issues oldest ready op.
// Insert-to-issue latency 2 edges; issue register holds while iss_ready is low; in_ready only from count.
module rs_multi_cdb #(
    parameter int DEPTH_BIT = 3,
    parameter int ROB_BIT   = 4,
    parameter int TYPE_BIT  = 5,
    parameter int XLEN      = 32,
    parameter int NUM_CDB   = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    rs_multi_cdb_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_BIT;

    logic [DEPTH-1:0]    busy_q, hd1_q, hd2_q;
    logic [TYPE_BIT-1:0] type_q [DEPTH];
    logic [ROB_BIT-1:0]  rob_q  [DEPTH];
    logic [ROB_BIT-1:0]  dep1_q [DEPTH];
    logic [ROB_BIT-1:0]  dep2_q [DEPTH];
    logic [XLEN-1:0]     r1_q   [DEPTH];
    logic [XLEN-1:0]     r2_q   [DEPTH];
    // age_q[i][j] set means entry i is older than entry j
    logic [DEPTH-1:0]    age_q  [DEPTH];
    logic [DEPTH_BIT:0]  count_q, count_d;

    logic                iss_valid_q;
    logic [TYPE_BIT-1:0] iss_type_q;
    logic [ROB_BIT-1:0]  iss_rob_q;
    logic [XLEN-1:0]     iss_r1_q, iss_r2_q;

    logic [XLEN:0]       wk1 [DEPTH];
    logic [XLEN:0]       wk2 [DEPTH];
    logic [XLEN:0]       byp1, byp2;
    logic                ins_hit1, ins_hit2;
    logic [DEPTH-1:0]    ready;
    logic                sel_vld, older;
    logic [DEPTH_BIT-1:0] sel_idx, free_idx;
    logic                do_ins, do_load;

    // {hit, value}; scanning downward lets the lowest matching channel win
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [ROB_BIT-1:0]         tag,
        input logic [NUM_CDB-1:0]         vld,
        input logic [NUM_CDB*ROB_BIT-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]    vals
    );
        logic [XLEN:0] r;
        r = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (vld[k] && tags[k*ROB_BIT +: ROB_BIT] == tag)
                r = {1'b1, vals[k*XLEN +: XLEN]};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk1[i] = cdb_lookup(dep1_q[i], bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
            wk2[i] = cdb_lookup(dep2_q[i], bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
        end
    end

    assign byp1     = cdb_lookup(bus.in_dep1, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
    assign byp2     = cdb_lookup(bus.in_dep2, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
    assign ins_hit1 = bus.in_has_dep1 && byp1[XLEN];
    assign ins_hit2 = bus.in_has_dep2 && byp2[XLEN];
    assign ready    = busy_q & ~hd1_q & ~hd2_q;

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        older   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            older = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && !age_q[i][j])
                    older = 1'b0;
            end
            if (older) begin
                sel_vld = 1'b1;
                sel_idx = DEPTH_BIT'(i);
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i])
                free_idx = DEPTH_BIT'(i);
        end
    end

    assign bus.in_ready = rst_in && rdy_in && !flush_in && (count_q < (DEPTH_BIT+1)'(DEPTH));
    assign do_ins       = bus.in_valid && bus.in_ready;
    assign do_load      = rdy_in && !flush_in && sel_vld && (!iss_valid_q || bus.iss_ready);

    always_comb begin
        count_d = count_q;
        if (do_ins && !do_load)
            count_d = count_q + 1'b1;
        else if (!do_ins && do_load)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q      <= '0;
            hd1_q       <= '0;
            hd2_q       <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_type_q  <= '0;
            iss_rob_q   <= '0;
            iss_r1_q    <= '0;
            iss_r2_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i] <= '0;
                rob_q[i]  <= '0;
                dep1_q[i] <= '0;
                dep2_q[i] <= '0;
                r1_q[i]   <= '0;
                r2_q[i]   <= '0;
                age_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                busy_q      <= '0;
                iss_valid_q <= 1'b0;
                count_q     <= '0;
            end else begin
                count_q <= count_d;
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy_q[i] && hd1_q[i] && wk1[i][XLEN]) begin
                        hd1_q[i] <= 1'b0;
                        r1_q[i]  <= wk1[i][XLEN-1:0];
                    end
                    if (busy_q[i] && hd2_q[i] && wk2[i][XLEN]) begin
                        hd2_q[i] <= 1'b0;
                        r2_q[i]  <= wk2[i][XLEN-1:0];
                    end
                end
                if (do_load) begin
                    busy_q[sel_idx] <= 1'b0;
                    iss_valid_q     <= 1'b1;
                    iss_type_q      <= type_q[sel_idx];
                    iss_rob_q       <= rob_q[sel_idx];
                    iss_r1_q        <= r1_q[sel_idx];
                    iss_r2_q        <= r2_q[sel_idx];
                end else if (bus.iss_ready) begin
                    iss_valid_q <= 1'b0;
                end
                if (do_ins) begin
                    busy_q[free_idx] <= 1'b1;
                    type_q[free_idx] <= bus.in_type;
                    rob_q[free_idx]  <= bus.in_rob_id;
                    dep1_q[free_idx] <= bus.in_dep1;
                    dep2_q[free_idx] <= bus.in_dep2;
                    hd1_q[free_idx]  <= bus.in_has_dep1 && !ins_hit1;
                    hd2_q[free_idx]  <= bus.in_has_dep2 && !ins_hit2;
                    r1_q[free_idx]   <= ins_hit1 ? byp1[XLEN-1:0] : bus.in_r1;
                    r2_q[free_idx]   <= ins_hit2 ? byp2[XLEN-1:0] : bus.in_r2;
                    for (int j = 0; j < DEPTH; j++)
                        age_q[j][free_idx] <= busy_q[j];
                    age_q[free_idx] <= '0;
                end
            end
        end
    end

    assign bus.iss_valid  = iss_valid_q;
    assign bus.iss_type   = iss_type_q;
    assign bus.iss_rob_id = iss_rob_q;
    assign bus.iss_r1     = iss_r1_q;
    assign bus.iss_r2     = iss_r2_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: vector table, directed corner sequences, randomized run vs queue model.
// The model keeps waiting ops in a queue in arrival order, so oldest-first is "first ready in queue".
module tb_rs_multi_cdb;
    logic clk = 1'b0;
    logic rst_n, rdy, flush;
    int   total = 0;
    int   bad   = 0;

    rs_multi_cdb_if #(.DEPTH_BIT(3), .ROB_BIT(4), .TYPE_BIT(5), .XLEN(32), .NUM_CDB(2)) bus ();

    rs_multi_cdb #(.DEPTH_BIT(3), .ROB_BIT(4), .TYPE_BIT(5), .XLEN(32), .NUM_CDB(2)) dut (
        .clk_in  (clk),
        .rst_in  (rst_n),
        .rdy_in  (rdy),
        .flush_in(flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  typ;
        logic [3:0]  rob;
        logic [31:0] r1, r2;
        bit          h1, h2;
        logic [3:0]  d1, d2;
    } op_t;

    op_t mq[$];
    bit  m_iv;
    op_t m_iss;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input logic [3:0] tag, output logic [31:0] v);
        for (int k = 0; k < 2; k++) begin
            if (bus.cdb_valid[k] && bus.cdb_rob_id[k*4 +: 4] == tag) begin
                v = bus.cdb_value[k*32 +: 32];
                return 1'b1;
            end
        end
        v = '0;
        return 1'b0;
    endfunction

    task automatic model_edge();
        int sel;
        bit acc;
        logic [31:0] v;
        op_t n;
        if (!rdy) return;
        if (flush) begin
            mq.delete();
            m_iv = 1'b0;
            return;
        end
        acc = bus.in_valid && (mq.size() < 8);
        sel = -1;
        for (int i = 0; i < mq.size(); i++)
            if (sel < 0 && !mq[i].h1 && !mq[i].h2) sel = i;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].h1 && m_hit(mq[i].d1, v)) begin mq[i].h1 = 1'b0; mq[i].r1 = v; end
            if (mq[i].h2 && m_hit(mq[i].d2, v)) begin mq[i].h2 = 1'b0; mq[i].r2 = v; end
        end
        if (sel >= 0 && (!m_iv || bus.iss_ready)) begin
            m_iss = mq[sel];
            m_iv  = 1'b1;
            mq.delete(sel);
        end else if (bus.iss_ready) begin
            m_iv = 1'b0;
        end
        if (acc) begin
            n.typ = bus.in_type;   n.rob = bus.in_rob_id;
            n.r1  = bus.in_r1;     n.r2  = bus.in_r2;
            n.h1  = bus.in_has_dep1; n.h2 = bus.in_has_dep2;
            n.d1  = bus.in_dep1;   n.d2  = bus.in_dep2;
            if (n.h1 && m_hit(n.d1, v)) begin n.h1 = 1'b0; n.r1 = v; end
            if (n.h2 && m_hit(n.d2, v)) begin n.h2 = 1'b0; n.r2 = v; end
            mq.push_back(n);
        end
    endtask

    // Settle inputs, check in_ready, advance model and DUT one edge, compare against model.
    task automatic step();
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(rdy && !flush && mq.size() < 8));
        model_edge();
        @(posedge clk);
        #1;
        chk("m_iss_valid", 64'(bus.iss_valid), 64'(m_iv));
        chk("m_count", 64'(bus.count), 64'(mq.size()));
        if (m_iv) begin
            chk("m_iss_rob", 64'(bus.iss_rob_id), 64'(m_iss.rob));
            chk("m_iss_type", 64'(bus.iss_type), 64'(m_iss.typ));
            chk("m_iss_r1", 64'(bus.iss_r1), 64'(m_iss.r1));
            chk("m_iss_r2", 64'(bus.iss_r2), 64'(m_iss.r2));
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;    bus.in_type = '0;     bus.in_rob_id = '0;
        bus.in_r1 = '0;         bus.in_r2 = '0;
        bus.in_has_dep1 = 1'b0; bus.in_has_dep2 = 1'b0;
        bus.in_dep1 = '0;       bus.in_dep2 = '0;
        bus.cdb_valid = '0;     bus.cdb_rob_id = '0;  bus.cdb_value = '0;
        flush = 1'b0;           rdy = 1'b1;
    endtask

    task automatic set_ins(input logic [3:0] rob, input logic [4:0] typ, input logic [31:0] a,
                           input logic [31:0] b, input bit h1, input logic [3:0] d1,
                           input bit h2, input logic [3:0] d2);
        bus.in_valid = 1'b1; bus.in_rob_id = rob; bus.in_type = typ;
        bus.in_r1 = a; bus.in_r2 = b;
        bus.in_has_dep1 = h1; bus.in_dep1 = d1;
        bus.in_has_dep2 = h2; bus.in_dep2 = d2;
    endtask

    task automatic set_cdb(input int k, input logic [3:0] tag, input logic [31:0] val);
        bus.cdb_valid[k] = 1'b1;
        bus.cdb_rob_id[k*4 +: 4] = tag;
        bus.cdb_value[k*32 +: 32] = val;
    endtask

    typedef struct {
        logic [3:0]  rob;
        logic [4:0]  typ;
        logic [31:0] r1, r2;
        bit          h1;
        logic [3:0]  d1;
        bit          h2;
        logic [3:0]  d2;
        logic [1:0]  cv;
        logic [3:0]  t0;
        logic [31:0] v0;
        logic [3:0]  t1;
        logic [31:0] v1;
        bit          exp_iss;
        logic [31:0] e1, e2;
    } vec_t;

    vec_t vt[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4'd3, 5'd1, 32'd5,  32'd7,  1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 4'd0, 32'h0,  4'd0, 32'h0,   1'b1, 32'd5,      32'd7};
        vt[1] = '{4'd4, 5'd2, 32'd1,  32'd7,  1'b1, 4'd9, 1'b0, 4'd0, 2'b10, 4'd0, 32'h0,  4'd9, 32'hDEAD, 1'b1, 32'hDEAD,   32'd7};
        vt[2] = '{4'd5, 5'd3, 32'd0,  32'd0,  1'b1, 4'd2, 1'b1, 4'd6, 2'b11, 4'd6, 32'h66, 4'd2, 32'h22,   1'b1, 32'h22,     32'h66};
        vt[3] = '{4'd6, 5'd4, 32'd9,  32'd0,  1'b0, 4'd0, 1'b1, 4'd5, 2'b11, 4'd5, 32'hA0, 4'd5, 32'hB1,   1'b1, 32'd9,      32'hA0};
        vt[4] = '{4'd7, 5'd5, 32'd0,  32'd3,  1'b1, 4'd7, 1'b0, 4'd0, 2'b01, 4'd8, 32'h1,  4'd0, 32'h0,    1'b0, 32'd0,      32'd0};
        vt[5] = '{4'd8, 5'd6, 32'd0,  32'd3,  1'b1, 4'd7, 1'b0, 4'd0, 2'b00, 4'd7, 32'h1,  4'd7, 32'h2,    1'b0, 32'd0,      32'd0};
        vt[6] = '{4'd9, 5'd7, 32'd4,  32'd0,  1'b0, 4'd0, 1'b1, 4'd1, 2'b10, 4'd1, 32'h11, 4'd1, 32'h12,   1'b1, 32'd4,      32'h12};

        rst_n = 1'b0;
        idle();
        bus.iss_ready = 1'b0;
        m_iv = 1'b0;
        #3;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_iss_fields", {bus.iss_type, bus.iss_rob_id, bus.iss_r1[22:0]}, 64'd0);
        chk("rst_iss_r2", 64'(bus.iss_r2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single-op table from an empty station with the ALU always accepting
        foreach (vt[i]) begin
            idle();
            bus.iss_ready = 1'b1;
            set_ins(vt[i].rob, vt[i].typ, vt[i].r1, vt[i].r2, vt[i].h1, vt[i].d1, vt[i].h2, vt[i].d2);
            bus.cdb_valid = vt[i].cv;
            bus.cdb_rob_id = {vt[i].t1, vt[i].t0};
            bus.cdb_value = {vt[i].v1, vt[i].v0};
            step();
            chk("vec_ins_iss_valid", 64'(bus.iss_valid), 64'd0);
            chk("vec_ins_count", 64'(bus.count), 64'd1);
            idle();
            step();
            if (vt[i].exp_iss) begin
                chk("vec_iss_valid", 64'(bus.iss_valid), 64'd1);
                chk("vec_iss_rob", 64'(bus.iss_rob_id), 64'(vt[i].rob));
                chk("vec_iss_type", 64'(bus.iss_type), 64'(vt[i].typ));
                chk("vec_iss_r1", 64'(bus.iss_r1), 64'(vt[i].e1));
                chk("vec_iss_r2", 64'(bus.iss_r2), 64'(vt[i].e2));
                chk("vec_count0", 64'(bus.count), 64'd0);
            end else begin
                chk("vec_wait_valid", 64'(bus.iss_valid), 64'd0);
                chk("vec_wait_count", 64'(bus.count), 64'd1);
                flush = 1'b1;
                step();
                flush = 1'b0;
                chk("vec_flush_count", 64'(bus.count), 64'd0);
            end
            step();
            chk("vec_drain", 64'(bus.iss_valid), 64'd0);
        end

        // oldest-first: X(idx0) A(idx1) B(idx2), X leaves, C lands in idx0 below A
        idle();
        bus.iss_ready = 1'b0;
        set_ins(4'd10, 5'd0, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0); step();
        set_ins(4'd1, 5'd2, 32'd0, 32'h11, 1'b1, 4'd2, 1'b0, 4'd0);  step();
        set_ins(4'd2, 5'd3, 32'h22, 32'h33, 1'b0, 4'd0, 1'b0, 4'd0);
        set_cdb(0, 4'd12, 32'h1212);                                   step();
        idle();                                                        step();
        chk("age_x_rob", 64'(bus.iss_rob_id), 64'd10);
        chk("age_x_r1", 64'(bus.iss_r1), 64'h1212);
        bus.iss_ready = 1'b1;
        set_ins(4'd3, 5'd4, 32'd0, 32'h44, 1'b1, 4'd2, 1'b0, 4'd0);   step();
        chk("age_b_first", 64'(bus.iss_rob_id), 64'd2);
        idle();
        bus.iss_ready = 1'b0;
        set_cdb(0, 4'd2, 32'h2222);                                    step();
        chk("age_b_hold", 64'(bus.iss_rob_id), 64'd2);
        idle();
        bus.iss_ready = 1'b1;                                          step();
        chk("age_a_rob", 64'(bus.iss_rob_id), 64'd1);
        chk("age_a_r1", 64'(bus.iss_r1), 64'h2222);
        step();
        chk("age_c_rob", 64'(bus.iss_rob_id), 64'd3);
        chk("age_c_r1", 64'(bus.iss_r1), 64'h2222);
        step();
        chk("age_empty", 64'(bus.iss_valid), 64'd0);

        // full and backpressure
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_ins(4'(i + 1), 5'(i), 32'(100 + i), 32'(200 + i), 1'b0, 4'd0, 1'b0, 4'd0);
            step();
        end
        chk("full_count", 64'(bus.count), 64'd8);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        set_ins(4'd15, 5'd31, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_count", 64'(bus.count), 64'd8);
            chk("bp_rob", 64'(bus.iss_rob_id), 64'd1);
            chk("bp_r1", 64'(bus.iss_r1), 64'd100);
        end
        idle();
        bus.iss_ready = 1'b1;
        step();
        bus.iss_ready = 1'b0;
        #1;
        chk("pulse_count", 64'(bus.count), 64'd7);
        chk("pulse_in_ready", 64'(bus.in_ready), 64'd1);
        chk("pulse_rob", 64'(bus.iss_rob_id), 64'd2);
        bus.iss_ready = 1'b1;
        step();
        step();
        chk("pre_flush_count", 64'(bus.count), 64'd5);
        chk("pre_flush_valid", 64'(bus.iss_valid), 64'd1);

        // flush beats a same-cycle insert and issue acceptance
        set_ins(4'd14, 5'd1, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        flush = 1'b1;
        step();
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_valid", 64'(bus.iss_valid), 64'd0);
        idle();
        step();
        chk("post_flush_count", 64'(bus.count), 64'd0);
        chk("post_flush_valid", 64'(bus.iss_valid), 64'd0);

        // asynchronous reset between edges
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ins(4'(8 + i), 5'd2, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
            step();
        end
        idle();
        step();
        chk("pre_rst_count", 64'(bus.count), 64'd2);
        chk("pre_rst_valid", 64'(bus.iss_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.iss_valid), 64'd0);
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
        mq.delete();
        m_iv = 1'b0;
        #1;
        rst_n = 1'b1;

        // rdy_in low freezes wakeup
        bus.iss_ready = 1'b1;
        set_ins(4'd6, 5'd3, 32'd0, 32'h77, 1'b1, 4'd11, 1'b0, 4'd0);
        step();
        idle();
        rdy = 1'b0;
        set_cdb(1, 4'd11, 32'hBEEF);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("frz_count", 64'(bus.count), 64'd1);
            chk("frz_valid", 64'(bus.iss_valid), 64'd0);
        end
        idle();
        step();
        step();
        chk("frz_nowake_valid", 64'(bus.iss_valid), 64'd0);
        chk("frz_nowake_count", 64'(bus.count), 64'd1);
        set_cdb(0, 4'd11, 32'h1234);
        step();
        idle();
        step();
        chk("frz_wake_rob", 64'(bus.iss_rob_id), 64'd6);
        chk("frz_wake_r1", 64'(bus.iss_r1), 64'h1234);
        chk("frz_wake_count", 64'(bus.count), 64'd0);

        // randomized traffic against the queue model, alternating fill and drain phases
        for (int c = 0; c < 3000; c++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 63) == 0);
            set_ins(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                    ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 7)));
            bus.in_valid   = ($urandom_range(0, 9) < 6);
            bus.cdb_valid  = 2'($urandom_range(0, 3));
            bus.cdb_rob_id = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            bus.cdb_value  = {$urandom, $urandom};
            bus.iss_ready  = ((c / 200) % 2 == 1) ? ($urandom_range(0, 3) != 0)
                                                  : ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
- Parametrised reservation station for the out-of-order core, sitting between dispatch and one ALU.
- Holds up to 2^DEPTH_BIT waiting ops and wakes operands from NUM_CDB broadcast channels, for example ALU and LSB results.
- Issues the oldest ready op through a registered valid/ready port with backpressure.
- Supports a full flush on branch mispredict.

Parameters:
- DEPTH_BIT, 3: log2 of entry count (DEPTH = 1<<DEPTH_BIT).
- ROB_BIT, 4: ROB tag width.
- TYPE_BIT, 5: op-type code width.
- XLEN, 32: operand width.
- NUM_CDB, 2: number of result broadcast channels.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global enable; low freezes all state.
- flush_in  in  1  clears all entries and the issue register.
- in_valid  in  1  dispatch offers an op.
- in_ready  out  1  RS can accept an op this cycle.
- in_type  in  TYPE_BIT  op type.
- in_rob_id  in  ROB_BIT  destination ROB tag.
- in_r1, in_r2  in  XLEN  operand values, valid when no dependency.
- in_has_dep1, in_has_dep2  in  1  operand waits on a tag.
- in_dep1, in_dep2  in  ROB_BIT  producer tags.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_rob_id  in  NUM_CDB*ROB_BIT  flattened tags; channel k occupies bits [k*ROB_BIT +: ROB_BIT].
- cdb_value  in  NUM_CDB*XLEN  flattened values, same packing.
- iss_valid  out  1  issue register holds an op.
- iss_ready  in  1  ALU accepts the issued op.
- iss_type  out  TYPE_BIT  issued op type.
- iss_rob_id  out  ROB_BIT  issued op tag.
- iss_r1, iss_r2  out  XLEN  issued operands.
- count  out  DEPTH_BIT+1  occupied entries, excluding the issue register.

Behaviour:
- Reset (rst_in low, asynchronous):
  - All entries not busy; age matrix cleared; count = 0.
  - iss_valid = 0; iss_type, iss_rob_id, iss_r1, iss_r2 = 0.
  - in_ready = 0 while in reset.
  - If reset is asserted mid-operation, everything is dropped immediately.
- in_ready = rdy_in && !flush_in && (count < DEPTH). It is combinational from the registered count only, so a slot freed by an issue in the same cycle is not reused until the next cycle.
- Insert (edge with in_valid && in_ready):
  - The op is written into the lowest-index free entry.
  - Same-cycle CDB bypass: if in_has_depX and some channel k has cdb_valid[k] with a matching tag, the value is captured and has_depX is stored as 0.
  - The entry is marked younger than every currently busy entry.
- Wakeup (every rdy_in edge):
  - Every busy entry with has_depX = 1 and a tag match on any valid channel captures the value and clears has_depX.
  - If several channels match, the lowest channel index wins. This is legal but not expected.
- Ready and selection:
  - An entry is ready when busy && !has_dep1 && !has_dep2, evaluated on registered state.
  - An entry inserted or woken at edge E is first selectable for edge E+1.
  - Select rule is oldest-first by age matrix; no index-based fallback is needed because ages are total.
- Issue register:
  - It loads at an edge when (!iss_valid || iss_ready) and some entry is ready.
  - The selected entry is freed at that same edge.
  - If iss_valid && iss_ready and no entry is ready, iss_valid drops to 0.
  - If iss_valid && !iss_ready, all issue outputs hold stable.
- count: +1 on insert, -1 on load, unchanged when both or neither occur at the same edge.
- flush_in (sampled at edge, has priority over insert, wakeup and issue):
  - All busy bits, iss_valid and count are cleared next cycle.
  - An op in the issue register is discarded even if iss_ready = 1 in the flush cycle.
- rdy_in low: no state changes and in_ready = 0; issue outputs hold.
- Throughput is one insert and one issue per cycle. Minimum latency from insert with no deps to iss_valid is 2 edges.

Test Plan:
- Basic pass-through: after reset, insert op rob_id=3 (no deps, r1=5, r2=7, type=1) with iss_ready=1 -> iss_valid rises exactly 1 edge after the insert edge with rob_id=3, r1=5, r2=7; count returns to 0.
- Same-cycle bypass: insert op rob_id=4 with dep1=9 while cdb channel 1 broadcasts tag 9, value 0xDEAD -> the op issues with r1=0xDEAD and never waits.
- Oldest-first selection: insert A (dep on 2), B (ready), C (dep on 2), then broadcast tag 2 with iss_ready=0 throughout the inserts -> B issues first. After iss_ready=1 the order is A then C, despite A and C occupying any index order.
- Full and backpressure: fill 8 entries with iss_ready=0 -> in_ready=0 and count=8. A 9th in_valid is ignored. Outputs stay stable for 10 cycles. One iss_ready pulse gives count=7 and in_ready=1 on the following cycle.
- Flush mid-stream: with 5 entries busy and iss_valid=1, assert flush_in with in_valid=1 and iss_ready=1 -> the next cycle shows count=0 and iss_valid=0, and the offered op is not inserted.
- Async reset and freeze: drop rst_in between edges with entries busy -> iss_valid=0 and count=0 immediately, without waiting for an edge. Separately, holding rdy_in=0 for 4 cycles while the CDB broadcasts a matching tag -> no wakeup is captured and state is unchanged.
